// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Brief    : Iterative shift-and-add-3 binary-to-BCD converter, one bit/clock,
//            valid/ready on both sides, digit count and overflow reporting.
// Revision : 1.0
// ============================================================================
module bin2bcd_seq #(
   parameter  int BIN_W  = 8,
   parameter  int DIGITS = 3,
   localparam int NDW    = $clog2(DIGITS + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BIN_W-1:0]      in_bin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic [NDW-1:0]        out_ndigits,
   output logic                  out_ovf,
   output logic                  busy
);

   localparam int c_CNT_W = $clog2(BIN_W + 1);
   localparam int c_BCD_W = 4 * DIGITS;

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_SHIFT = 2'd1;
   localparam logic [1:0] c_DONE  = 2'd2;

   logic [1:0]         r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic [BIN_W-1:0]   r_bin;
   logic [c_BCD_W-1:0] r_bcd;
   logic               r_ovf;

   logic [c_BCD_W-1:0] w_adj;
   logic [c_BCD_W-1:0] w_next_bcd;
   logic               w_next_ovf;
   logic [NDW-1:0]     w_next_nd;

   // Adjusted digits never exceed 12, so each digit stays within its nibble.
   for (genvar d = 0; d < DIGITS; d++) begin : g_adj
      assign w_adj[4*d +: 4] = (r_bcd[4*d +: 4] >= 4'd5) ? (r_bcd[4*d +: 4] + 4'd3)
                                                         : r_bcd[4*d +: 4];
   end

   assign w_next_bcd = {w_adj[c_BCD_W-2:0], r_bin[BIN_W-1]};
   assign w_next_ovf = r_ovf | w_adj[c_BCD_W-1];

   always_comb begin
      w_next_nd = NDW'(1);
      for (int i = 0; i < DIGITS; i++) begin
         if (w_next_bcd[4*i +: 4] != 4'd0) begin
            w_next_nd = NDW'(i + 1);
         end
      end
   end

   assign in_ready  = (r_state == c_IDLE);
   assign busy      = (r_state == c_SHIFT);
   assign out_valid = (r_state == c_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_IDLE;
         r_cnt       <= '0;
         r_bin       <= '0;
         r_bcd       <= '0;
         r_ovf       <= 1'b0;
         out_bcd     <= '0;
         out_ndigits <= '0;
         out_ovf     <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (in_valid) begin
                  r_bin   <= in_bin;
                  r_bcd   <= '0;
                  r_ovf   <= 1'b0;
                  r_cnt   <= c_CNT_W'(BIN_W);
                  r_state <= c_SHIFT;
               end
            end
            c_SHIFT: begin
               r_bcd <= w_next_bcd;
               r_bin <= r_bin << 1;
               r_ovf <= w_next_ovf;
               r_cnt <= r_cnt - c_CNT_W'(1);
               if (r_cnt == c_CNT_W'(1)) begin
                  out_bcd     <= w_next_bcd;
                  out_ovf     <= w_next_ovf;
                  out_ndigits <= w_next_nd;
                  r_state     <= c_DONE;
               end
            end
            c_DONE: begin
               if (out_ready) begin
                  r_state <= c_IDLE;
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// Bench for bin2bcd_seq: three configurations (8b/3d, 16b/5d, 8b/2d) checked
// against an arithmetic decimal model every cycle, plus literal expectations.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  in_valid;
   logic [2:0]  out_ready;
   logic [15:0] in_bin;
   logic [2:0]  in_ready, out_valid, busy, ovf_a;
   logic [11:0] bcd0;
   logic [19:0] bcd1;
   logic [7:0]  bcd2;
   logic [1:0]  nd0, nd2;
   logic [2:0]  nd1;
   logic [19:0] bcd_a [3];
   logic [2:0]  nd_a  [3];

   int bw [3] = '{8, 16, 8};
   int dg [3] = '{3, 5, 2};

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_d0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_bin(in_bin[7:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_bcd(bcd0), .out_ndigits(nd0), .out_ovf(ovf_a[0]), .busy(busy[0]));

   bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_bin(in_bin), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_bcd(bcd1), .out_ndigits(nd1), .out_ovf(ovf_a[1]), .busy(busy[1]));

   bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_d2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_bin(in_bin[7:0]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .out_bcd(bcd2), .out_ndigits(nd2), .out_ovf(ovf_a[2]), .busy(busy[2]));

   assign bcd_a[0] = {8'h00, bcd0};
   assign bcd_a[1] = bcd1;
   assign bcd_a[2] = {12'h000, bcd2};
   assign nd_a[0]  = {1'b0, nd0};
   assign nd_a[1]  = nd1;
   assign nd_a[2]  = {1'b0, nd2};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Decimal model: value mod 10^d in packed nibbles, significant digits, overflow.
   function automatic void model(input int v, input int d, output logic [19:0] b,
                                 output int nd, output bit o);
      int p = 1;
      int m;
      for (int i = 0; i < d; i++) p = p * 10;
      o  = (v >= p);
      m  = v % p;
      b  = '0;
      nd = 1;
      for (int i = 0; i < d; i++) begin
         b[4*i +: 4] = 4'(m % 10);
         if (m % 10 != 0) nd = i + 1;
         m = m / 10;
      end
   endfunction

   bit          pending   [3];
   bit          prev_valid[3];
   int          acc_cyc   [3];
   int          busy_cnt  [3];
   logic [19:0] exp_bcd   [3];
   int          exp_nd    [3];
   bit          exp_ovf   [3];
   logic [19:0] hold_bcd  [3];
   logic [2:0]  hold_nd   [3];
   logic        hold_ovf  [3];

   always @(negedge clk) begin
      cyc++;
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            pending[k]    = 1'b0;
            prev_valid[k] = 1'b0;
            chk("rst_in_ready",  in_ready[k],  1);
            chk("rst_out_valid", out_valid[k], 0);
            chk("rst_busy",      busy[k],      0);
            chk("rst_bcd",       bcd_a[k],     0);
            chk("rst_ndigits",   nd_a[k],      0);
            chk("rst_ovf",       ovf_a[k],     0);
         end else begin
            if (busy[k]) begin
               busy_cnt[k]++;
               chk("in_ready_while_busy", in_ready[k], 0);
            end
            if (out_valid[k] && !prev_valid[k]) begin
               chk("valid_without_accept", pending[k], 1);
               if (pending[k]) begin
                  chk("model_bcd",     bcd_a[k],           exp_bcd[k]);
                  chk("model_ndigits", nd_a[k],            exp_nd[k]);
                  chk("model_ovf",     ovf_a[k],           exp_ovf[k]);
                  chk("latency",       cyc - acc_cyc[k],   bw[k]);
                  chk("busy_cycles",   busy_cnt[k],        bw[k]);
                  chk("in_ready_done", in_ready[k],        0);
               end
               pending[k]  = 1'b0;
               hold_bcd[k] = bcd_a[k];
               hold_nd[k]  = nd_a[k];
               hold_ovf[k] = ovf_a[k];
            end else if (out_valid[k]) begin
               chk("hold_bcd",      bcd_a[k],    hold_bcd[k]);
               chk("hold_ndigits",  nd_a[k],     hold_nd[k]);
               chk("hold_ovf",      ovf_a[k],    hold_ovf[k]);
               chk("hold_in_ready", in_ready[k], 0);
            end else if (prev_valid[k]) begin
               chk("ready_after_hs", in_ready[k], 1);
               chk("bcd_kept",       bcd_a[k],    hold_bcd[k]);
            end
            if (in_valid[k] && in_ready[k]) begin
               int nd;
               bit o;
               pending[k]  = 1'b1;
               acc_cyc[k]  = cyc + 1;
               busy_cnt[k] = 0;
               model(int'(in_bin) & ((1 << bw[k]) - 1), dg[k], exp_bcd[k], nd, o);
               exp_nd[k]  = nd;
               exp_ovf[k] = o;
            end
            prev_valid[k] = out_valid[k];
         end
      end
   end

   task automatic convert(input int k, input int v, input int hold);
      int t;
      out_ready[k] = (hold == 0);
      t = 0;
      while (!in_ready[k] && t < 50) begin @(posedge clk); #1; t++; end
      if (!in_ready[k]) begin chk("in_ready_timeout", in_ready[k], 1); return; end
      in_valid[k] = 1'b1;
      in_bin      = 16'(v);
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
      in_bin      = 16'hA5A5;
      t = 0;
      while (!out_valid[k] && t < 50) begin @(posedge clk); #1; t++; end
      if (!out_valid[k]) begin chk("out_valid_timeout", out_valid[k], 1); return; end
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            in_valid[k] = (i < hold - 1);
            in_bin      = 16'd77;
            @(posedge clk); #1;
         end
         out_ready[k] = 1'b1;
         @(posedge clk); #1;
         chk("bp_in_ready_after", in_ready[k], 1);
      end else begin
         @(posedge clk); #1;
      end
      out_ready[k] = 1'b0;
   endtask

   task automatic expect_out(input int k, input logic [19:0] b, input int nd, input bit o);
      chk("lit_bcd",     bcd_a[k], b);
      chk("lit_ndigits", nd_a[k],  nd);
      chk("lit_ovf",     ovf_a[k], o);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = '0;
      out_ready = '0;
      in_bin    = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      convert(0, 255, 0);  expect_out(0, 20'h00255, 3, 0);
      convert(0, 0, 0);    expect_out(0, 20'h00000, 1, 0);
      convert(0, 9, 0);    expect_out(0, 20'h00009, 1, 0);
      convert(0, 10, 0);   expect_out(0, 20'h00010, 2, 0);
      convert(0, 128, 5);  expect_out(0, 20'h00128, 3, 0);

      convert(1, 65535, 0); expect_out(1, 20'h65535, 5, 0);
      convert(1, 1000, 0);  expect_out(1, 20'h01000, 4, 0);
      convert(1, 12345, 2); expect_out(1, 20'h12345, 5, 0);

      convert(2, 99, 0);   expect_out(2, 20'h99, 2, 0);
      convert(2, 100, 0);  expect_out(2, 20'h00, 1, 1);
      convert(2, 237, 0);  expect_out(2, 20'h37, 2, 1);
      convert(2, 5, 0);    expect_out(2, 20'h05, 1, 0);

      // Abort a conversion of 200 after four shift steps.
      out_ready[0] = 1'b1;
      in_valid[0]  = 1'b1;
      in_bin       = 16'd200;
      @(posedge clk); #1;
      in_valid[0]  = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_out_valid", out_valid[0], 0);
      chk("abort_in_ready",  in_ready[0],  1);
      chk("abort_busy",      busy[0],      0);
      chk("abort_bcd",       bcd_a[0],     0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         chk("no_valid_after_abort", out_valid[0], 0);
      end
      convert(0, 42, 0);   expect_out(0, 20'h00042, 2, 0);
      convert(0, 1, 0);    expect_out(0, 20'h00001, 1, 0);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
